banked_sram_mrd: RTL and testbench

//  Multi-bank on-chip buffer for the LeNet feature-map/weight path: one write port, NUM_RD parallel read ports.
//  Low-order address interleaving across NUM_BANKS dual-port banks gives the conv engine conflict-free

---
 rtl/banked_sram_mrd_if.sv | 28 ++
 rtl/banked_sram_mrd.sv | 126 ++++++++++++
 tb/tb_banked_sram_mrd.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/banked_sram_mrd_if.sv
// Bus bundle for banked_sram_mrd: clear control, one write port and NUM_RD read ports.
interface banked_sram_mrd_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_RD     = 2
);
    logic                           csen;
    logic                           init_start;
    logic                           init_busy;
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic [NUM_RD-1:0]              rd_req;
    logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
    logic [NUM_RD-1:0]              rd_gnt;
    logic [NUM_RD-1:0]              rd_valid;
    logic [NUM_RD*DATA_WIDTH-1:0]   rd_data;

    modport master (
        output csen, init_start, wr_en, wr_addr, wr_data, rd_req, rd_addr,
        input  init_busy, rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  csen, init_start, wr_en, wr_addr, wr_data, rd_req, rd_addr,
        output init_busy, rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/banked_sram_mrd.sv
// Low-order interleaved multi-bank buffer: one write port, NUM_RD arbitrated read ports with
// fixed-latency pipelined data, write-first bypass and a row-sequential clear engine.
module banked_sram_mrd #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    banked_sram_mrd_if.slave bus
);
    localparam int unsigned BANK_SHIFT = $clog2(NUM_BANKS);
    localparam int unsigned BANK_BITS  = (BANK_SHIFT > 0) ? BANK_SHIFT : 1;
    localparam int unsigned ROW_BITS   = ADDR_WIDTH - BANK_SHIFT;
    localparam int unsigned ROWS       = 2 ** ROW_BITS;
    localparam logic [BANK_BITS-1:0] BANK_MASK = BANK_BITS'(NUM_BANKS - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return a[BANK_BITS-1:0] & BANK_MASK;
    endfunction

    function automatic logic [ROW_BITS-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:BANK_SHIFT];
    endfunction

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

    state_e                state_q, state_d;
    logic [ROW_BITS-1:0]   row_cnt_q, row_cnt_d;
    logic                  idle, wr_acc;
    logic [NUM_RD-1:0]     rd_gnt;
    logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_RD];
    logic [DATA_WIDTH-1:0] rd_word   [NUM_RD];

    logic [NUM_RD-1:0]     vld_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY][NUM_RD];

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        unique case (state_q)
            StClear: begin
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == ROW_BITS'(ROWS - 1)) state_d = StIdle;
            end
            StIdle: begin
                if (bus.csen && bus.init_start) begin
                    state_d   = StClear;
                    row_cnt_d = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    assign idle   = (state_q == StIdle);
    // A write coinciding with a clear request is dropped.
    assign wr_acc = idle && bus.csen && bus.wr_en && !bus.init_start;

    // Lower-indexed ports win a bank; identical addresses share the access.
    always_comb begin
        rd_gnt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_a[i] = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int i = 0; i < NUM_RD; i++) begin
            rd_gnt[i] = idle && bus.csen && bus.rd_req[i];
            for (int j = 0; j < i; j++) begin
                if (bus.rd_req[j] && bank_of(rd_addr_a[j]) == bank_of(rd_addr_a[i]) &&
                    rd_addr_a[j] != rd_addr_a[i]) begin
                    rd_gnt[i] = 1'b0;
                end
            end
            if (wr_acc && rd_addr_a[i] == bus.wr_addr) rd_word[i] = bus.wr_data;
            else rd_word[i] = mem[bank_of(rd_addr_a[i])][row_of(rd_addr_a[i])];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            for (int b = 0; b < NUM_BANKS; b++) mem[b][row_cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[bank_of(bus.wr_addr)][row_of(bus.wr_addr)] <= bus.wr_data;
        end
    end

    // Each stage only loads on a valid, so the last stage holds its data between valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            row_cnt_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_q[s] <= '0;
                for (int i = 0; i < NUM_RD; i++) dat_q[s][i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            vld_q[0]  <= rd_gnt;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_gnt[i]) dat_q[0][i] <= rd_word[i];
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                for (int i = 0; i < NUM_RD; i++) begin
                    if (vld_q[s-1][i]) dat_q[s][i] <= dat_q[s-1][i];
                end
            end
        end
    end

    assign bus.init_busy = (state_q == StClear);
    assign bus.rd_gnt    = rd_gnt;
    assign bus.rd_valid  = vld_q[RD_LATENCY-1];

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[RD_LATENCY-1][i];
        end
    end
endmodule

// File: tb/tb_banked_sram_mrd.sv
// Directed, table-driven bench for banked_sram_mrd (4 banks, 2 read ports, latency 2).
module tb_banked_sram_mrd;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt;

    banked_sram_mrd_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_RD(2)) bus ();

    banked_sram_mrd #(
        .DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_BANKS(4), .NUM_RD(2), .RD_LATENCY(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       csen;
        logic       wr_en;
        logic [9:0] wa;
        logic [7:0] wd;
        logic [1:0] req;
        logic [9:0] a0;
        logic [9:0] a1;
        logic [1:0] gnt;
        logic [1:0] vld;
        logic [7:0] d0;
        logic [7:0] d1;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic cs, input logic we, input logic [9:0] wa,
                                input logic [7:0] wd, input logic [1:0] req,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [1:0] gnt, input logic [1:0] vld,
                                input logic [7:0] d0, input logic [7:0] d1);
        vec_t v;
        v.csen = cs; v.wr_en = we; v.wa = wa; v.wd = wd; v.req = req; v.a0 = a0; v.a1 = a1;
        v.gnt = gnt; v.vld = vld; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered at posedge+1; single port-0 read, checks grant and data two cycles later.
    task automatic rd_check(input logic [9:0] addr, input logic [7:0] exp, input string nm);
        bus.rd_req  = 2'b01;
        bus.rd_addr = {10'd0, addr};
        #1 chk({nm, " gnt"}, 32'(bus.rd_gnt), 32'h1);
        @(posedge clk); #1;
        bus.rd_req = 2'b00;
        @(posedge clk); #1;
        chk({nm, " valid"}, 32'(bus.rd_valid), 32'h1);
        chk({nm, " data"}, 32'(bus.rd_data[7:0]), 32'(exp));
    endtask

    task automatic count_busy(input int chk_at, input string nm);
        cnt = 0;
        while (bus.init_busy && cnt < 1000) begin
            cnt++;
            if (cnt == chk_at) chk({nm, " gnt during clear"}, 32'(bus.rd_gnt), 32'h0);
            @(posedge clk); #1;
        end
        chk({nm, " busy cycles"}, 32'(cnt), 32'd256);
    endtask

    initial begin
        vt[0]  = mk(1, 1, 10'd5,  8'hA5, 2'b00, 10'd0,  10'd0,  2'b00, 2'b00, 8'h00, 8'h00);
        vt[1]  = mk(1, 1, 10'd12, 8'h77, 2'b01, 10'd5,  10'd0,  2'b01, 2'b00, 8'h00, 8'h00);
        vt[2]  = mk(1, 1, 10'd7,  8'h11, 2'b11, 10'd4,  10'd8,  2'b01, 2'b00, 8'h00, 8'h00);
        vt[3]  = mk(1, 0, 10'd0,  8'h00, 2'b10, 10'd0,  10'd8,  2'b10, 2'b01, 8'hA5, 8'h00);
        vt[4]  = mk(1, 0, 10'd0,  8'h00, 2'b11, 10'd4,  10'd5,  2'b11, 2'b01, 8'h00, 8'h00);
        vt[5]  = mk(1, 0, 10'd0,  8'h00, 2'b11, 10'd12, 10'd12, 2'b11, 2'b10, 8'h00, 8'h00);
        vt[6]  = mk(1, 1, 10'd7,  8'h3C, 2'b10, 10'd0,  10'd7,  2'b10, 2'b11, 8'h00, 8'hA5);
        vt[7]  = mk(1, 0, 10'd0,  8'h00, 2'b00, 10'd0,  10'd0,  2'b00, 2'b11, 8'h77, 8'h77);
        vt[8]  = mk(1, 0, 10'd0,  8'h00, 2'b00, 10'd0,  10'd0,  2'b00, 2'b10, 8'h77, 8'h3C);
        vt[9]  = mk(1, 1, 10'd1,  8'h42, 2'b01, 10'd7,  10'd0,  2'b01, 2'b00, 8'h77, 8'h3C);
        vt[10] = mk(1, 0, 10'd0,  8'h00, 2'b11, 10'd1,  10'd2,  2'b11, 2'b00, 8'h77, 8'h3C);
        vt[11] = mk(1, 0, 10'd0,  8'h00, 2'b00, 10'd0,  10'd0,  2'b00, 2'b01, 8'h3C, 8'h3C);
        vt[12] = mk(1, 0, 10'd0,  8'h00, 2'b01, 10'd3,  10'd0,  2'b01, 2'b11, 8'h42, 8'h00);
        vt[13] = mk(0, 1, 10'd3,  8'h99, 2'b01, 10'd3,  10'd0,  2'b00, 2'b00, 8'h42, 8'h00);
        vt[14] = mk(1, 0, 10'd0,  8'h00, 2'b01, 10'd3,  10'd0,  2'b01, 2'b01, 8'h00, 8'h00);
        vt[15] = mk(1, 0, 10'd0,  8'h00, 2'b00, 10'd0,  10'd0,  2'b00, 2'b00, 8'h00, 8'h00);
        vt[16] = mk(1, 0, 10'd0,  8'h00, 2'b00, 10'd0,  10'd0,  2'b00, 2'b01, 8'h00, 8'h00);

        rst_n          = 1'b0;
        bus.csen       = 1'b1;
        bus.init_start = 1'b0;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 10'd5;
        bus.wr_data    = 8'hFF;
        bus.rd_req     = 2'b11;
        bus.rd_addr    = '0;

        #12;
        chk("reset busy", 32'(bus.init_busy), 32'h1);
        chk("reset gnt", 32'(bus.rd_gnt), 32'h0);
        chk("reset valid", 32'(bus.rd_valid), 32'h0);
        chk("reset data", 32'(bus.rd_data), 32'h0);

        // Writes and reads presented during the power-up clear must be ignored.
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(50, "init");
        bus.wr_en  = 1'b0;
        bus.rd_req = 2'b00;

        rd_check(10'h3FF, 8'h00, "top addr");
        rd_check(10'd5, 8'h00, "write during clear");
        @(posedge clk); #1;

        for (int k = 0; k < 17; k++) begin
            bus.csen    = vt[k].csen;
            bus.wr_en   = vt[k].wr_en;
            bus.wr_addr = vt[k].wa;
            bus.wr_data = vt[k].wd;
            bus.rd_req  = vt[k].req;
            bus.rd_addr = {vt[k].a1, vt[k].a0};
            #1;
            chk($sformatf("vec%0d gnt", k), 32'(bus.rd_gnt), 32'(vt[k].gnt));
            chk($sformatf("vec%0d valid", k), 32'(bus.rd_valid), 32'(vt[k].vld));
            chk($sformatf("vec%0d data0", k), 32'(bus.rd_data[7:0]), 32'(vt[k].d0));
            chk($sformatf("vec%0d data1", k), 32'(bus.rd_data[15:8]), 32'(vt[k].d1));
            @(posedge clk); #1;
        end
        bus.csen   = 1'b1;
        bus.wr_en  = 1'b0;
        bus.rd_req = 2'b00;

        // Clear request with a simultaneous (dropped) write.
        bus.init_start = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 10'd20;
        bus.wr_data    = 8'hEE;
        @(posedge clk); #1;
        bus.init_start = 1'b0;
        bus.wr_en      = 1'b0;
        bus.rd_req     = 2'b11;
        bus.rd_addr    = {10'd9, 10'd5};
        count_busy(100, "init_start");
        bus.rd_req = 2'b00;
        rd_check(10'd5,  8'h00, "clear 5");
        rd_check(10'd12, 8'h00, "clear 12");
        rd_check(10'd7,  8'h00, "clear 7");
        rd_check(10'd1,  8'h00, "clear 1");
        rd_check(10'd20, 8'h00, "clear 20");

        // Reset partway through a clear restarts it from row 0.
        bus.init_start = 1'b1;
        @(posedge clk); #1;
        bus.init_start = 1'b0;
        for (int k = 0; k < 99; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(bus.init_busy), 32'h1);
        chk("mid reset valid", 32'(bus.rd_valid), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(10, "restart");
        rd_check(10'h3FF, 8'h00, "after restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
